// File: rtl/alu_result_sink.sv
// alu_result_sink: DEPTH-entry valid/ready FIFO for ALU {result,zero} pairs with status Z, saturating zero counter and optional zero recheck (ALU_ZERO_RECHECK_EN); ports clk, rst_n, in_valid/in_ready/in_data/in_zero, out_valid/out_ready/out_data/out_zero, status_z, zero_cnt, count, err_flag
module alu_result_sink #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4,
  parameter int CNT_W = 16
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [WIDTH-1:0]           in_data,
  input  logic                       in_zero,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [WIDTH-1:0]           out_data,
  output logic                       out_zero,
  output logic                       status_z,
  output logic [CNT_W-1:0]           zero_cnt,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       err_flag
);
  localparam int AW = $clog2(DEPTH);
  logic [WIDTH-1:0] data_q [DEPTH];
  logic             zero_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [AW:0]      count_q, count_d;
  logic             status_z_q;
  logic [CNT_W-1:0] zero_cnt_q, zero_cnt_d;
  logic             push, pop, z_st;
  assign in_ready  = count_q != (AW+1)'(DEPTH);
  assign out_valid = count_q != '0;
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;
  assign out_data  = out_valid ? data_q[rd_ptr_q] : '0;
  assign out_zero  = out_valid & zero_q[rd_ptr_q];
  assign status_z  = status_z_q;
  assign zero_cnt  = zero_cnt_q;
  assign count     = count_q;
`ifdef ALU_ZERO_RECHECK_EN
  logic err_q;
  assign z_st     = in_data == '0;
  assign err_flag = err_q;
  always_ff @(posedge clk)
    if (!rst_n) err_q <= 1'b0;
    else if (push && in_zero != z_st) err_q <= 1'b1;
`else
  assign z_st     = in_zero;
  assign err_flag = 1'b0;
`endif
  always_comb begin
    count_d    = count_q + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
    zero_cnt_d = (push && z_st && !(&zero_cnt_q)) ? zero_cnt_q + 1'b1 : zero_cnt_q;
  end
  always_ff @(posedge clk)
    if (push) begin
      data_q[wr_ptr_q] <= in_data;
      zero_q[wr_ptr_q] <= z_st;
    end
  always_ff @(posedge clk)
    if (!rst_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      status_z_q <= 1'b0;
      zero_cnt_q <= '0;
    end else begin
      wr_ptr_q   <= push ? wr_ptr_q + 1'b1 : wr_ptr_q;
      rd_ptr_q   <= pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
      count_q    <= count_d;
      status_z_q <= push ? z_st : status_z_q;
      zero_cnt_q <= zero_cnt_d;
    end
endmodule

// File: tb/tb_alu_result_sink.sv
// tb_alu_result_sink: directed and random stimulus against a queue-based reference model
module tb_alu_result_sink;
  localparam int WIDTH = 32;
  localparam int DEPTH = 4;
  localparam int CNT_W = 3;
  localparam int ZMAX  = (1 << CNT_W) - 1;
`ifdef ALU_ZERO_RECHECK_EN
  localparam bit RECHECK = 1'b1;
`else
  localparam bit RECHECK = 1'b0;
`endif
  typedef struct packed {logic [WIDTH-1:0] d; logic z;} ent_t;
  logic clk = 1'b0;
  logic rst_n, in_valid, in_zero, out_ready;
  logic [WIDTH-1:0] in_data;
  logic in_ready, out_valid, out_zero, status_z, err_flag;
  logic [WIDTH-1:0] out_data;
  logic [CNT_W-1:0] zero_cnt;
  logic [$clog2(DEPTH):0] count;
  ent_t q[$];
  logic m_stz, m_err;
  int m_zc;
  int n_vec = 0;
  int n_err = 0;
  alu_result_sink #(.WIDTH(WIDTH), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_zero(in_zero), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_zero(out_zero), .status_z(status_z), .zero_cnt(zero_cnt), .count(count), .err_flag(err_flag)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask
  task automatic cycle(input logic rn, input logic iv, input logic [WIDTH-1:0] id, input logic iz, input logic ordy);
    bit do_push, do_pop, zc;
    rst_n = rn; in_valid = iv; in_data = id; in_zero = iz; out_ready = ordy;
    @(negedge clk);
    chk("in_ready", in_ready, q.size() < DEPTH);
    chk("out_valid", out_valid, q.size() > 0);
    chk("out_data", out_data, q.size() > 0 ? q[0].d : '0);
    chk("out_zero", out_zero, q.size() > 0 ? q[0].z : 1'b0);
    chk("count", count, q.size());
    chk("status_z", status_z, m_stz);
    chk("zero_cnt", zero_cnt, m_zc);
    chk("err_flag", err_flag, m_err);
    if (!rn) begin
      q.delete(); m_stz = 0; m_zc = 0; m_err = 0;
    end else begin
      do_push = iv && q.size() < DEPTH;
      do_pop  = ordy && q.size() > 0;
      zc = RECHECK ? (id == 0) : iz;
      if (do_pop) void'(q.pop_front());
      if (do_push) begin
        q.push_back('{d: id, z: zc});
        m_stz = zc;
        if (zc && m_zc < ZMAX) m_zc++;
        if (RECHECK && iz != zc) m_err = 1;
      end
    end
    @(posedge clk);
    #1;
  endtask
  initial begin
    logic [WIDTH-1:0] d;
    q.delete(); m_stz = 0; m_zc = 0; m_err = 0;
    rst_n = 0; in_valid = 0; in_data = 0; in_zero = 0; out_ready = 0;
    @(posedge clk); #1;
    cycle(0, 0, 0, 0, 0);
    cycle(1, 1, 32'h0, 1, 0);
    cycle(1, 0, 0, 0, 0);
    cycle(0, 0, 0, 0, 0);
    for (int i = 1; i <= 5; i++) cycle(1, 1, WIDTH'(i), 0, 0);
    for (int i = 0; i < 6; i++) cycle(1, 0, 0, 0, 1);
    for (int i = 1; i <= 4; i++) cycle(1, 1, WIDTH'(i), 0, 0);
    cycle(1, 1, 32'h55, 0, 1);
    cycle(1, 1, 32'h66, 0, 0);
    for (int i = 0; i < 5; i++) cycle(1, 0, 0, 0, 1);
    cycle(0, 0, 0, 0, 0);
    for (int i = 0; i < 20; i++) cycle(1, 1, WIDTH'(i), i == 0, 1);
    cycle(1, 0, 0, 0, 1);
    for (int i = 0; i < 9; i++) cycle(1, 1, 0, 1, 1);
    cycle(0, 1, 0, 1, 1);
    cycle(1, 0, 0, 0, 0);
    cycle(1, 1, 32'h00FF_0000, 1, 0);
    cycle(1, 0, 0, 0, 1);
    cycle(1, 0, 0, 0, 1);
    cycle(0, 0, 0, 0, 0);
    for (int i = 0; i < 600; i++) begin
      d = ($urandom_range(0, 3) == 0) ? '0 : WIDTH'($urandom);
      cycle($urandom_range(0, 60) != 0, $urandom_range(0, 2) != 0, d,
            ($urandom_range(0, 7) == 0) ? (d != 0) : (d == 0), $urandom_range(0, 2) != 0);
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
